// File: rtl/inv_zigzag_scan.sv
`default_nettype none
// ============================================================================
// Module   : inv_zigzag_scan
// Purpose  : Inverse zigzag scan for 8x8 blocks. Zigzag-ordered coefficients
//            are written into a ping-pong buffer at their raster position.
//            Each completed bank is then streamed out in raster order
//            (row*8+col), one sample per cycle, with no gaps.
// Options  : INV_ZIGZAG_IDX_OUT_EN adds dout_idx, the raster index of dout.
// Revision : 1.0  initial release
// ============================================================================
module inv_zigzag_scan #(
   parameter int DW  = 10,
   parameter int BLK = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vld_in,
   input  logic [DW-1:0] din,
   output logic          rdy_in,
   output logic          vld_out,
   output logic [DW-1:0] dout,
   output logic          sob_out,
   output logic          eob_out
`ifdef INV_ZIGZAG_IDX_OUT_EN
   ,
   output logic [5:0]    dout_idx
`endif
);

   // Zigzag position k -> raster position (row*8+col); a permutation of 0..63.
   localparam logic [5:0] ZZ_TAB [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_READ = 1'b1
   } state_t;

   // Two banks back to back: address = {bank, raster index}.
   logic [DW-1:0] bank_mem [0:2*BLK-1];

   state_t        state_q,   state_d;
   logic [1:0]    full_q,    full_d;
   logic          wr_sel_q,  wr_sel_d;
   logic          rd_sel_q,  rd_sel_d;
   logic [5:0]    wr_cnt_q,  wr_cnt_d;
   logic [5:0]    rd_cnt_q,  rd_cnt_d;
   logic          vld_out_q, vld_out_d;
   logic [DW-1:0] dout_q,    dout_d;
   logic          sob_q,     sob_d;
   logic          eob_q,     eob_d;
   logic          wr_fire;
   logic          rd_last;

   // A bank marked full is either waiting to be read or being read, so it
   // must not accept writes.
   assign rdy_in  = !full_q[wr_sel_q];
   assign wr_fire = vld_in && rdy_in;
   assign rd_last = (state_q == S_READ) && (rd_cnt_q == 6'd63);

   // Write side: scatter each zigzag sample to its raster slot.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         bank_mem[{wr_sel_q, ZZ_TAB[wr_cnt_q]}] <= din;
      end
   end

   // Next-state: write counter, bank flags, read FSM and output register.
   always_comb begin
      state_d   = state_q;
      full_d    = full_q;
      wr_sel_d  = wr_sel_q;
      rd_sel_d  = rd_sel_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      vld_out_d = 1'b0;
      dout_d    = dout_q;
      sob_d     = 1'b0;
      eob_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (full_q[rd_sel_q]) begin
               state_d  = S_READ;
               rd_cnt_d = 6'd0;
            end
         end
         S_READ: begin
            dout_d    = bank_mem[{rd_sel_q, rd_cnt_q}];
            vld_out_d = 1'b1;
            sob_d     = (rd_cnt_q == 6'd0);
            eob_d     = (rd_cnt_q == 6'd63);
            rd_cnt_d  = rd_cnt_q + 6'd1;
            if (rd_last) begin
               full_d[rd_sel_q] = 1'b0;
               rd_sel_d         = ~rd_sel_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Read and write banks always differ when both flags change together.
      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + 6'd1;
         if (wr_cnt_q == 6'd63) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
         end
      end

      // Continue straight into the other bank if it is (or just became) full.
      if (rd_last && !full_d[~rd_sel_q]) begin
         state_d = S_IDLE;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         full_q    <= 2'b00;
         wr_sel_q  <= 1'b0;
         rd_sel_q  <= 1'b0;
         wr_cnt_q  <= 6'd0;
         rd_cnt_q  <= 6'd0;
         vld_out_q <= 1'b0;
         dout_q    <= '0;
         sob_q     <= 1'b0;
         eob_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         wr_sel_q  <= wr_sel_d;
         rd_sel_q  <= rd_sel_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         vld_out_q <= vld_out_d;
         dout_q    <= dout_d;
         sob_q     <= sob_d;
         eob_q     <= eob_d;
      end
   end

   assign vld_out = vld_out_q;
   assign dout    = dout_q;
   assign sob_out = sob_q;
   assign eob_out = eob_q;

`ifdef INV_ZIGZAG_IDX_OUT_EN
   logic [5:0] idx_q, idx_d;

   // Raster index travels with the sample it describes.
   always_comb begin
      idx_d = idx_q;
      if (state_q == S_READ) begin
         idx_d = rd_cnt_q;
      end
   end

   // Index register.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= 6'd0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign dout_idx = idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inv_zigzag_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_zigzag_scan
// Purpose  : Self-checking bench for inv_zigzag_scan. Accepted input blocks
//            are reordered by a diagonal-walk reference model and queued;
//            every output sample is popped and compared.
// Revision : 1.0  initial release
// ============================================================================
module tb_inv_zigzag_scan;

   localparam int DW = 10;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          sob;
      logic          eob;
      logic [5:0]    idx;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          vld_in = 1'b0;
   logic [DW-1:0] din = '0;
   logic          rdy_in;
   logic          vld_out;
   logic [DW-1:0] dout;
   logic          sob_out;
   logic          eob_out;
`ifdef INV_ZIGZAG_IDX_OUT_EN
   logic [5:0]    dout_idx;
`endif

   int n_checks  = 0;
   int n_errors  = 0;
   int cyc       = 0;
   int in_cnt    = 0;
   int out_pos   = 0;
   int last63    = 0;
   int cur_run   = 0;
   int max_run   = 0;
   int stall_cnt = 0;
   bit lat_en    = 1'b0;
   bit anchor_en = 1'b0;
   bit post_rst  = 1'b0;

   exp_t          exp_q[$];
   exp_t          e;
   logic [DW-1:0] in_blk [64];
   logic [DW-1:0] ras    [64];

   int anc_pos [8] = '{0, 1, 2, 3, 8, 9, 16, 63};
   int anc_val [8] = '{0, 1, 5, 6, 2, 4, 3, 63};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   inv_zigzag_scan #(.DW(DW), .BLK(64)) dut (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (vld_in),
      .din     (din),
      .rdy_in  (rdy_in),
      .vld_out (vld_out),
      .dout    (dout),
      .sob_out (sob_out),
      .eob_out (eob_out)
`ifdef INV_ZIGZAG_IDX_OUT_EN
      ,
      .dout_idx(dout_idx)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference zigzag: walk anti-diagonals, odd ones with row rising.
   function automatic int zz_ref(input int k);
      int n = 0;
      for (int d = 0; d < 15; d++) begin
         int lo = (d > 7) ? d - 7 : 0;
         int hi = (d < 7) ? d : 7;
         for (int i = 0; i <= hi - lo; i++) begin
            int r = (d % 2 == 1) ? lo + i : hi - i;
            if (n == k) return r * 8 + (d - r);
            n++;
         end
      end
      return 0;
   endfunction

   // Monitor: scoreboard pop on output, model push on accepted input.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         in_cnt  = 0;
         out_pos = 0;
         cur_run = 0;
      end else begin
         if (post_rst) begin
            check_eq("rst_vld_out", vld_out, 0);
            check_eq("rst_sob_out", sob_out, 0);
            check_eq("rst_eob_out", eob_out, 0);
            check_eq("rst_dout", dout, 0);
            check_eq("rst_rdy_in", rdy_in, 1);
`ifdef INV_ZIGZAG_IDX_OUT_EN
            check_eq("rst_dout_idx", dout_idx, 0);
`endif
            post_rst = 1'b0;
         end
         if (vld_out) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            if (exp_q.size() == 0) begin
               check_eq("spurious_vld_out", vld_out, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("dout", dout, e.d);
               check_eq("sob_out", sob_out, e.sob);
               check_eq("eob_out", eob_out, e.eob);
`ifdef INV_ZIGZAG_IDX_OUT_EN
               check_eq("dout_idx", dout_idx, e.idx);
`endif
               if (lat_en && out_pos == 0) begin
                  check_eq("latency", cyc, last63 + 2);
                  lat_en = 1'b0;
               end
               if (anchor_en) begin
                  for (int i = 0; i < 8; i++) begin
                     if (out_pos == anc_pos[i]) check_eq("anchor", dout, anc_val[i]);
                  end
               end
               out_pos = (out_pos + 1) % 64;
            end
         end else begin
            cur_run = 0;
            if (out_pos != 0) begin
               check_eq("gap_in_block", vld_out, 1);
               out_pos = 0;
            end
         end
         if (vld_in && !rdy_in) stall_cnt++;
         if (vld_in && rdy_in) begin
            in_blk[in_cnt] = din;
            if (in_cnt == 63) begin
               last63 = cyc + 1;
               for (int k = 0; k < 64; k++) ras[zz_ref(k)] = in_blk[k];
               for (int r = 0; r < 64; r++) begin
                  exp_q.push_back(exp_t'{d: ras[r], sob: (r == 0), eob: (r == 63), idx: 6'(r)});
               end
            end
            in_cnt = (in_cnt + 1) % 64;
         end
      end
   end

   // mode 0: base+k, mode 1: base+ZZ(k) (raster ascending), other: random.
   task automatic send_block(input int base, input int mode, input int gap_pct, input int n,
                             output bit first_rdy, output bit eob_at_first);
      logic [DW-1:0] v;
      int tries;
      first_rdy    = 1'b0;
      eob_at_first = 1'b0;
      for (int k = 0; k < n; k++) begin
         case (mode)
            0:       v = DW'(base + k);
            1:       v = DW'(base + zz_ref(k));
            default: v = DW'($urandom_range(0, 1023));
         endcase
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            vld_in = 1'b0;
            din    = DW'($urandom);
            @(posedge clk); #1;
         end
         vld_in = 1'b1;
         din    = v;
         tries  = 0;
         forever begin
            @(negedge clk);
            if (k == 0 && tries == 0) first_rdy = rdy_in;
            if (rdy_in) begin
               if (k == 0) eob_at_first = eob_out;
               @(posedge clk); #1;
               break;
            end
            tries++;
            if (tries > 300) begin
               check_eq("accept_timeout", rdy_in, 1);
               @(posedge clk); #1;
               break;
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic drain();
      vld_in = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !vld_out) break;
      end
      check_eq("drain", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      vld_in = 1'b0;
      rst    = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      post_rst = 1'b1;
   endtask

   initial begin
      bit fr, eo;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      post_rst = 1'b1;
      @(posedge clk); #1;

      // Single block, din=k: anchors, framing and latency.
      anchor_en = 1'b1;
      lat_en    = 1'b1;
      send_block(0, 0, 0, 64, fr, eo);
      drain();
      anchor_en = 1'b0;

      // din=ZZ(k): raster output ascends 0..63.
      send_block(0, 1, 0, 64, fr, eo);
      drain();

      // Four back-to-back blocks, values 0..255 in raster order.
      max_run   = 0;
      stall_cnt = 0;
      for (int b = 0; b < 4; b++) send_block(64 * b, 1, 0, 64, fr, eo);
      drain();
      check_eq("contiguous_run", max_run, 256);
      // Both banks are full for exactly one cycle, just before the first
      // block's last read, so at most one offered sample waits.
      check_eq("stall_bound", (stall_cnt <= 1), 1);

      // Both banks full, third block offered.
      send_block(100, 0, 0, 64, fr, eo);
      send_block(300, 0, 0, 64, fr, eo);
      send_block(500, 0, 0, 64, fr, eo);
      check_eq("rdy_low_both_full", fr, 0);
      check_eq("rdy_rise_at_eob", eo, 1);
      drain();

      // Random input gaps with random data.
      for (int b = 0; b < 3; b++) send_block(0, 2, 50, 64, fr, eo);
      drain();

      // Reset at input sample 30 of the third block.
      send_block(0, 0, 0, 64, fr, eo);
      send_block(64, 0, 0, 64, fr, eo);
      send_block(128, 0, 0, 30, fr, eo);
      pulse_reset();
      @(posedge clk); #1;
      lat_en = 1'b1;
      send_block(200, 0, 0, 64, fr, eo);
      drain();

      // Reset during output sample 10.
      send_block(300, 1, 0, 64, fr, eo);
      vld_in = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (out_pos >= 10) break;
      end
      check_eq("reached_out10", out_pos, 10);
      pulse_reset();
      @(posedge clk); #1;
      lat_en = 1'b1;
      send_block(700, 0, 0, 64, fr, eo);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
